// File: rtl/ula_seq_pkg.sv
// Shared op encodings and FSM state type for the sequential ALU.
// The MUL state only exists when ULA_SEQ_MUL_EN is defined.
package ula_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SUB = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_EQU = 3'b010;
    localparam logic [OP_W-1:0] OP_SLT = 3'b011;
    localparam logic [OP_W-1:0] OP_MUL = 3'b100;

`ifdef ULA_SEQ_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/ula_seq_if.sv
// Operand/result handshake bundle between the operand registers, the ALU and write-back.
interface ula_seq_if #(parameter int WIDTH = 64);
    import ula_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [OP_W-1:0]   op;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              v;
    logic              err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, v, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, v, err
    );

endinterface

// File: rtl/ula_seq_mul.sv
// Signed shift-add multiplier on operand magnitudes, sign restored at the output.
// Latency: WIDTH cycles from start to a one-cycle done pulse; product is valid while done is high.
// Backpressure: none; caller must not pulse start while an operation is in flight.
module ula_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic               neg;

    // -MIN wraps back to MIN, whose bit pattern is exactly its unsigned magnitude.
    assign mag_a   = a[MSB] ? -a : a;
    assign mag_b   = b[MSB] ? -b : b;
    assign product = neg ? -acc : acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            neg    <= 1'b0;
        end else if (start) begin
            // The first partial product is folded into the load cycle.
            acc    <= mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, mag_a, 1'b0};
            mplier <= mag_b >> 1;
            cnt    <= CW'(1);
            busy   <= 1'b1;
            done   <= 1'b0;
            neg    <= a[MSB] ^ b[MSB];
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Multi-cycle two's-complement ALU (SUB/ADD/EQU/SLT, MUL when ULA_SEQ_MUL_EN is defined).
// Latency: result registered on the accept edge; MUL takes WIDTH further cycles.
// Backpressure: result held until out_ready in DONE; in_ready only while IDLE.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic     clock,
    input  logic     reset_n,
    ula_seq_if.slave bus
);

    localparam int MSB = WIDTH - 1;

    state_t            state;
    logic [WIDTH-1:0]  result_q;
    logic              v_q;
    logic              err_q;

    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              a_eq_b;
    logic              a_lt_b;

    assign sum     = bus.a + bus.b;
    assign diff    = bus.a - bus.b;
    assign add_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB]  != bus.a[MSB]);
    assign sub_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
    assign a_eq_b  = (bus.a == bus.b);
    assign a_lt_b  = ($signed(bus.a) < $signed(bus.b));

`ifdef ULA_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic               mul_ovf;

    assign mul_start = (state == ST_IDLE) && bus.in_valid && (bus.op == OP_MUL);
    assign mul_ovf   = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[MSB]}});

    ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (product)
    );
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            result_q <= '0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state <= ST_DONE;
                        v_q   <= 1'b0;
                        err_q <= 1'b0;
                        case (bus.op)
                            OP_SUB: begin
                                result_q <= diff;
                                v_q      <= sub_ovf;
                            end
                            OP_ADD: begin
                                result_q <= sum;
                                v_q      <= add_ovf;
                            end
                            OP_EQU:  result_q <= {{(WIDTH-1){1'b0}}, a_eq_b};
                            OP_SLT:  result_q <= {{(WIDTH-1){1'b0}}, a_lt_b};
`ifdef ULA_SEQ_MUL_EN
                            OP_MUL:  state <= ST_MUL;
`endif
                            default: begin
                                result_q <= '0;
                                err_q    <= 1'b1;
                            end
                        endcase
                    end
                end
`ifdef ULA_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        result_q <= product[MSB:0];
                        v_q      <= mul_ovf;
                        state    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.v         = v_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq at WIDTH=8: directed vector table, handshake/reset sequences, random ops vs model.
module tb_ula_seq;
    import ula_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ula_seq_if #(.WIDTH(W)) bus();

    ula_seq #(.WIDTH(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         v;
        logic         e;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap and range-test.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic v, output logic e,
                                  output int lat);
        longint sa, sb, full, hi, lo;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        hi  = (longint'(1) << (W - 1)) - 1;
        lo  = -(longint'(1) << (W - 1));
        r   = '0;
        v   = 1'b0;
        e   = 1'b0;
        lat = 0;
        case (op)
            OP_SUB: begin full = sa - sb; r = W'(full); v = (full > hi) || (full < lo); end
            OP_ADD: begin full = sa + sb; r = W'(full); v = (full > hi) || (full < lo); end
            OP_EQU: r = (sa == sb) ? W'(1) : W'(0);
            OP_SLT: r = (sa <  sb) ? W'(1) : W'(0);
`ifdef ULA_SEQ_MUL_EN
            OP_MUL: begin full = sa * sb; r = W'(full); v = (full > hi) || (full < lo); lat = W; end
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Issue one op from IDLE, wait for out_valid, then consume it.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ordy, output logic [W-1:0] r, output logic v,
                          output logic e, output int lat, output logic ov_after);
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r = bus.result;
        v = bus.v;
        e = bus.err;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        ov_after      = bus.out_valid;
        bus.out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic v, input logic e, input int lat);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.r = r; t.v = v; t.e = e; t.lat = lat;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         vecs[13];
        logic [W-1:0] r;
        logic         v, e, ova;
        int           lat;
        logic [W-1:0] er;
        logic         ev, ee;
        int           elat;

        vecs[0]  = mk(OP_ADD, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0, 0);
        vecs[1]  = mk(OP_ADD, 8'd100, 8'd28, 8'h80, 1'b1, 1'b0, 0);
        vecs[2]  = mk(OP_SUB, 8'h80,  8'h01, 8'h7F, 1'b1, 1'b0, 0);
        vecs[3]  = mk(OP_SUB, 8'd5,   8'd7,  8'hFE, 1'b0, 1'b0, 0);
        vecs[4]  = mk(OP_SLT, 8'hFF,  8'h00, 8'h01, 1'b0, 1'b0, 0);
        vecs[5]  = mk(OP_SLT, 8'h00,  8'hFF, 8'h00, 1'b0, 1'b0, 0);
        vecs[6]  = mk(OP_EQU, 8'd5,   8'd5,  8'h01, 1'b0, 1'b0, 0);
        vecs[7]  = mk(OP_EQU, 8'd5,   8'd6,  8'h00, 1'b0, 1'b0, 0);
        vecs[8]  = mk(3'b110, 8'd3,   8'd4,  8'h00, 1'b0, 1'b1, 0);
        vecs[9]  = mk(3'b111, 8'hFF,  8'hFF, 8'h00, 1'b0, 1'b1, 0);
`ifdef ULA_SEQ_MUL_EN
        vecs[10] = mk(OP_MUL, 8'h80,  8'hFF, 8'h80, 1'b1, 1'b0, W);
        vecs[11] = mk(OP_MUL, 8'hF9,  8'd9,  8'hC1, 1'b0, 1'b0, W);
        vecs[12] = mk(OP_MUL, 8'h80,  8'h80, 8'h00, 1'b1, 1'b0, W);
`else
        vecs[10] = mk(OP_MUL, 8'h80,  8'hFF, 8'h00, 1'b0, 1'b1, 0);
        vecs[11] = mk(OP_MUL, 8'hF9,  8'd9,  8'h00, 1'b0, 1'b1, 0);
        vecs[12] = mk(OP_MUL, 8'h80,  8'h80, 8'h00, 1'b0, 1'b1, 0);
`endif

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b1;
        #2 rst_n      = 1'b0;
        #10;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_v",         32'(bus.v),         32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, v, e, lat, ova);
            check($sformatf("vec%0d_result", i), 32'(r),   32'(vecs[i].r));
            check($sformatf("vec%0d_v", i),      32'(v),   32'(vecs[i].v));
            check($sformatf("vec%0d_err", i),    32'(e),   32'(vecs[i].e));
            check($sformatf("vec%0d_lat", i),    32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: hold DONE for 5 cycles while a competing request waits.
        bus.op = OP_ADD; bus.a = 8'd10; bus.b = 8'd20;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.op = OP_SUB; bus.a = 8'd1; bus.b = 8'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", k),    32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d_result", k),   32'(bus.result),    32'd30);
            check($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_valid",  32'(bus.out_valid), 32'd1);
        check("bp_next_result", 32'(bus.result),    32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of an in-flight op (MUL, or a held illegal result).
        bus.op = OP_MUL; bus.a = 8'h85; bus.b = 8'h33; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result",    32'(bus.result),    32'd0);
        check("midrst_v",         32'(bus.v),         32'd0);
        check("midrst_err",       32'(bus.err),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        run_op(OP_ADD, 8'd3, 8'd4, 1'b0, r, v, e, lat, ova);
        check("post_rst_add", 32'(r), 32'd7);
        check("post_rst_lat", 32'(lat), 32'd0);

        // Random ops with out_ready held high: one-cycle out_valid per op.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 8'h80 : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
            model(rop, ra, rb, er, ev, ee, elat);
            run_op(rop, ra, rb, 1'b1, r, v, e, lat, ova);
            check($sformatf("rnd%0d_result op=%0d a=%0h b=%0h", i, rop, ra, rb), 32'(r), 32'(er));
            check($sformatf("rnd%0d_v", i),    32'(v),   32'(ev));
            check($sformatf("rnd%0d_err", i),  32'(e),   32'(ee));
            check($sformatf("rnd%0d_lat", i),  32'(lat), 32'(elat));
            check($sformatf("rnd%0d_onecycle", i), 32'(ova), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
